// File: rtl/twofish_keyed_sbox_pipe.sv
// ---------------------------------------------------------------------------
// twofish_keyed_sbox_pipe
//
// Pipelined Twofish keyed S-box layer (the byte path of h()) for 128/192/256
// bit keys, selected per transaction. Five q-layers A..E, one registered
// stage after each. Layers A..D XOR a key byte after the q permutation;
// layer E does not. In k2 mode A and B are bypassed, in k3 mode only A is.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = ~stall)
//   in_x                  input word, byte0 = in_x[31:24] .. byte3 = in_x[7:0]
//   in_s0..in_s3          key words, byte i of each word feeds byte lane i
//   in_klen               0 = k2, 1 = k3, 2/3 = k4
//   in_tag                sideband returned unchanged with the result
//   out_valid / out_ready output handshake
//   out_y, out_tag        result word and its tag
//   busy                  any stage holds a valid transaction
// ---------------------------------------------------------------------------
module twofish_keyed_sbox_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_s0,
    input  logic [31:0]      in_s1,
    input  logic [31:0]      in_s2,
    input  logic [31:0]      in_s3,
    input  logic [1:0]       in_klen,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // q0/q1 nibble tables t0..t3, entry 0 in the most significant nibble.
    localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
    localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
    localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
    localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
    localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
    localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
    localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
    localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

    // Per-layer q selection, bit i = lane i, 1 selects q1.
    localparam logic [3:0] SEL_A = 4'b1001;
    localparam logic [3:0] SEL_B = 4'b0011;
    localparam logic [3:0] SEL_C = 4'b1010;
    localparam logic [3:0] SEL_D = 4'b1100;
    localparam logic [3:0] SEL_E = 4'b0101;

    function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
        logic [63:0] sh;
        sh = tbl >> (6'd60 - {idx, 2'b00});
        return sh[3:0];
    endfunction

    function automatic logic [3:0] ror4(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

    // Twofish q permutation: two rounds of nibble mixing and table lookup.
    // The (8*a mod 16) term reduces to a[0] shifted into the top bit.
    function automatic logic [7:0] q_perm(input logic use_q1, input logic [7:0] x);
        logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
        a1 = x[7:4] ^ x[3:0];
        b1 = x[7:4] ^ ror4(x[3:0]) ^ {x[4], 3'b000};
        a2 = nib(use_q1 ? Q1_T0 : Q0_T0, a1);
        b2 = nib(use_q1 ? Q1_T1 : Q0_T1, b1);
        a3 = a2 ^ b2;
        b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
        a4 = nib(use_q1 ? Q1_T2 : Q0_T2, a3);
        b4 = nib(use_q1 ? Q1_T3 : Q0_T3, b3);
        return {b4, a4};
    endfunction

    logic             stall;
    logic             accept;
    logic [5:1]       valid_reg;
    logic [31:0]      data_reg [1:5];
    logic [TAG_W-1:0] tag_reg  [1:5];
    // Key material only travels as far as the last layer that needs it.
    logic [1:0]       klen1_reg;
    logic [31:0]      s0_1_reg, s1_1_reg, s2_1_reg;
    logic [31:0]      s0_2_reg, s1_2_reg;
    logic [31:0]      s1_3_reg;

    logic [31:0] a_out, b_out, c_out, d_out, e_out;

    assign stall     = valid_reg[5] & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_reg[5];
    assign out_y     = data_reg[5];
    assign out_tag   = tag_reg[5];
    assign busy      = |valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HI = 31 - 8 * gi;
            assign a_out[HI -: 8] = in_klen[1]
                ? (q_perm(SEL_A[gi], in_x[HI -: 8]) ^ in_s3[HI -: 8])
                : in_x[HI -: 8];
            assign b_out[HI -: 8] = (klen1_reg != 2'd0)
                ? (q_perm(SEL_B[gi], data_reg[1][HI -: 8]) ^ s2_1_reg[HI -: 8])
                : data_reg[1][HI -: 8];
            assign c_out[HI -: 8] = q_perm(SEL_C[gi], data_reg[2][HI -: 8]) ^ s0_2_reg[HI -: 8];
            assign d_out[HI -: 8] = q_perm(SEL_D[gi], data_reg[3][HI -: 8]) ^ s1_3_reg[HI -: 8];
            assign e_out[HI -: 8] = q_perm(SEL_E[gi], data_reg[4][HI -: 8]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            for (int i = 1; i <= 5; i++) begin
                data_reg[i] <= '0;
                tag_reg[i]  <= '0;
            end
            klen1_reg <= '0;
            s0_1_reg  <= '0;
            s1_1_reg  <= '0;
            s2_1_reg  <= '0;
            s0_2_reg  <= '0;
            s1_2_reg  <= '0;
            s1_3_reg  <= '0;
        end else if (!stall) begin
            // Every stage shifts, bubbles included, so latency stays fixed.
            valid_reg   <= {valid_reg[4:1], accept};
            data_reg[1] <= a_out;
            data_reg[2] <= b_out;
            data_reg[3] <= c_out;
            data_reg[4] <= d_out;
            data_reg[5] <= e_out;
            tag_reg[1]  <= in_tag;
            for (int i = 2; i <= 5; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            klen1_reg <= in_klen;
            s0_1_reg  <= in_s0;
            s1_1_reg  <= in_s1;
            s2_1_reg  <= in_s2;
            s0_2_reg  <= s0_1_reg;
            s1_2_reg  <= s1_1_reg;
            s1_3_reg  <= s1_2_reg;
        end
    end

endmodule

// File: doc/twofish_keyed_sbox_pipe.md
# twofish_keyed_sbox_pipe

Pipelined, key-length-configurable Twofish keyed S-box layer (the h-function byte path). It generalises the fixed two-key-byte S-box to 128/192/256-bit keys (k = 2/3/4 key words) selected per transaction, with a valid/ready elastic interface and an optional sideband tag. It sits between the round-function input mux and the MDS stage, and also serves the key-schedule h() path.

## Interface
- TAG_W, 4: width of opaque sideband tag carried alongside each word (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_x  in  32  input word; byte0 = in_x[31:24] … byte3 = in_x[7:0]
- in_s0, in_s1, in_s2, in_s3  in  32 each  key words; byte i of each word feeds byte lane i
- in_klen  in  2  0 = k2 (128-bit), 1 = k3 (192-bit), 2 = k4 (256-bit), 3 = treated as k4
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_y  out  32  result word, same byte order as in_x
- out_tag  out  TAG_W  tag of the transaction in out_y
- busy  out  1  any pipeline stage holds a valid transaction

## Operation
- Five q-layers A..E, each: per-byte q permutation (existing Q0/Q1 modules), then XOR with a key byte (layers A-D) or no XOR (E).
- Per byte lane 0/1/2/3: A = q1/q0/q0/q1 then ^S3; B = q1/q1/q0/q0 then ^S2; C = q0/q1/q0/q1 then ^S0; D = q0/q0/q1/q1 then ^S1; E = q1/q0/q1/q0.
- k2: A and B are pass-through (no q, no XOR). k3: A pass-through, B active. k4: all active. C/D/E always active; k2 result equals the legacy fixed keyed S-box.
- Key words, klen and tag are captured at acceptance and travel with the data; every transaction may use different keys/mode.
- Unused key words (S2/S3 in k2, S3 in k3) are don't-care and must not affect out_y.
- Stage registers after each layer: 5 registered stages, each with a valid bit.
- Global stall: stall = out_valid & ~out_ready. When stall, no stage register or valid bit changes. Otherwise every stage advances one position (bubbles advance too; no bubble collapse).
- in_ready = ~stall (combinational from out_valid register and out_ready). Transfer on in_valid & in_ready; stage-1 valid loads in_valid & in_ready.
- Reset: all stage valid bits clear → out_valid = 0, busy = 0, in_ready = 1; out_y, out_tag = 0 (data registers cleared too). Reset mid-flight discards all in-flight transactions; no output for them ever appears.

## Timing
- Latency fixed 5 cycles from accepting edge to out_valid, independent of klen, absent stall.
- Throughput 1 word/cycle with out_ready held high.
- out_y/out_tag stable while out_valid & ~out_ready.
- Stall of N cycles adds exactly N cycles to every in-flight transaction; order always preserved.
- Transaction on out accepted on the same edge a new one enters: both occur, no loss.
- rst takes priority over all handshake activity on the same edge.
- busy = OR of the 5 stage valid bits (registered sources only).

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 → out_valid = 0, busy = 0, in_ready = 1, out_y = 0; no transfer occurs.
- k2 sanity: in_x = 0, S0 = S1 = 0, klen = 0, tag = 0x5 → out_valid exactly 5 cycles later, out_y = golden Q0/Q1 composition (byte0 = q1(q0(q0(0x00)))), tag 0x5; repeat with random S2/S3 → identical out_y.
- Mode sweep: same in_x = 0x01234567, S0..S3 = 0x00112233/0x44556677/0x8899AABB/0xCCDDEEFF with klen 0,1,2,3 back to back → four distinct results matching golden model; klen 3 equals klen 2.
- Streaming: 64 random words, out_ready = 1 → one result per cycle, in order, 5-cycle latency, tags 0..63 in sequence.
- Backpressure: random out_ready (50 %) with continuous in_valid → no loss/duplication, out_y/out_tag stable during stall, in_ready low exactly when out_valid & ~out_ready.
- Reset mid-flight: 3 words accepted, rst at cycle 2 → no out_valid after reset; next accepted word emerges 5 cycles after acceptance with correct value.
